// File: rtl/cam_buf_pkg.sv
// Shared defaults and width helper for the camera ping-pong column buffer.
package cam_buf_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ROWS_DEF   = 26;
  localparam int COLS_DEF   = 34;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cam_buf_bank.sv
// One ROWS x COLS pixel bank: single write port, registered whole-column read.
// CAM_BUF_MEM_CLR_EN: reset also zeroes the storage (register array instead of RAM).
module cam_buf_bank
  import cam_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF,
  localparam int RW    = cnt_w(ROWS),
  localparam int CW    = cnt_w(COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [RW-1:0]          wr_row_i,
  input  logic [CW-1:0]          wr_col_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  input  logic                   rd_en_i,
  input  logic [CW-1:0]          rd_col_i,
  output logic [ROWS*DATA_W-1:0] rd_col_o
);

  logic [DATA_W-1:0]      mem_q [ROWS][COLS];
  logic [ROWS*DATA_W-1:0] col_q;

`ifdef CAM_BUF_MEM_CLR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mem_q[r][c] <= '0;
    end else if (we_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_row_i][wr_col_i] <= wr_data_i;
  end
`endif

  // Row 0 lands in the MSBs of the column word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
    end else if (rd_en_i) begin
      for (int r = 0; r < ROWS; r++)
        col_q[(ROWS-r)*DATA_W-1 -: DATA_W] <= mem_q[r][rd_col_i];
    end
  end

  assign rd_col_o = col_q;

endmodule

// File: rtl/cam_pingpong_buf.sv
// Double-banked column buffer: camera fills one bank column-major while the PE
// array reads whole columns from the other. Storage reset via CAM_BUF_MEM_CLR_EN.
module cam_pingpong_buf
  import cam_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     rd_req,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic                     rd_valid,
  output logic [ROWS*DATA_W-1:0]   rd_data,
  input  logic                     rd_release,
  output logic [1:0]               bank_full,
  output logic                     rd_bank
);

  localparam int RW = cnt_w(ROWS);
  localparam int CW = cnt_w(COLS);

  logic          wr_bank_q, wr_bank_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          rd_valid_q;
  logic          sel_q;

  logic wr_fire, row_last, col_last, rd_fire, rel;
  logic [ROWS*DATA_W-1:0] col0, col1;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign row_last = (wr_row_q == RW'(ROWS-1));
  assign col_last = (wr_col_q == CW'(COLS-1));
  assign rd_fire  = rd_req && full_q[rd_bank_q] && ({1'b0, rd_col} < (CW+1)'(COLS));
  assign rel      = rd_release && full_q[rd_bank_q];

  always_comb begin
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      if (row_last) begin
        wr_row_d = '0;
        if (col_last) begin
          wr_col_d          = '0;
          wr_bank_d         = ~wr_bank_q;
          full_d[wr_bank_q] = 1'b1;
        end else begin
          wr_col_d = wr_col_q + 1'b1;
        end
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
    // Writer never targets a full bank, so this cannot undo the set above.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      rd_bank_q  <= 1'b0;
      full_q     <= 2'b00;
      rd_valid_q <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      rd_bank_q  <= rd_bank_d;
      full_q     <= full_d;
      rd_valid_q <= rd_fire;
      if (rd_fire) sel_q <= rd_bank_q;
    end
  end

  cam_buf_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) u_bank0 (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wr_fire && !wr_bank_q),
    .wr_row_i  (wr_row_q),
    .wr_col_i  (wr_col_q),
    .wr_data_i (in_data),
    .rd_en_i   (rd_fire && !rd_bank_q),
    .rd_col_i  (rd_col),
    .rd_col_o  (col0)
  );

  cam_buf_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS)) u_bank1 (
    .clk       (clk),
    .rst       (rst),
    .we_i      (wr_fire && wr_bank_q),
    .wr_row_i  (wr_row_q),
    .wr_col_i  (wr_col_q),
    .wr_data_i (in_data),
    .rd_en_i   (rd_fire && rd_bank_q),
    .rd_col_i  (rd_col),
    .rd_col_o  (col1)
  );

  // Bank registers hold between reads, so the muxed output holds too.
  assign rd_data   = sel_q ? col1 : col0;
  assign rd_valid  = rd_valid_q;
  assign bank_full = full_q;
  assign rd_bank   = rd_bank_q;

endmodule

// File: doc/cam_pingpong_buf.md
# cam_pingpong_buf

Parametrised, double-banked column buffer for the camera input path. It accepts a pixel stream over a valid/ready handshake and fills a ROWS×COLS bank column by column: consecutive pixels go down a column, then on to the next column. It returns one whole column, ROWS pixels, in parallel to the PE array. Two banks ping-pong, so the PE side reads a complete frame tile while the camera side fills the other.

## Interface
Parameters:
- DATA_W, 8: pixel width in bits
- ROWS, 26: pixels per column, which is also the parallel read width
- COLS, 34: columns per bank

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  pixel present on in_data
- in_data  in  DATA_W  pixel value
- in_ready  out  1  buffer can accept a pixel
- rd_req  in  1  column read request
- rd_col  in  $clog2(COLS)  column index to read from the current read bank
- rd_valid  out  1  rd_data holds the requested column
- rd_data  out  ROWS*DATA_W  column data; row 0 in the MSBs, row r at bits [(ROWS-r)*DATA_W-1 -: DATA_W]
- rd_release  in  1  reader is done with the current read bank
- bank_full  out  2  per-bank full flags
- rd_bank  out  1  index of the bank currently presented to the reader

## Operation
- Internal state:
  - wr_bank (1b), wr_row, wr_col counters.
  - rd_bank (1b), full[1:0].
  - Storage: 2 × ROWS × COLS × DATA_W.
- in_ready is combinational: !full[wr_bank].
- Write accepted when in_valid && in_ready. The pixel is stored at [wr_bank][wr_row][wr_col].
  - wr_row increments.
  - At wr_row == ROWS-1, wr_row wraps to 0 and wr_col increments.
- Last pixel of a bank (wr_row == ROWS-1, wr_col == COLS-1):
  - full[wr_bank] <= 1.
  - Counters clear to 0.
  - wr_bank toggles.
- Write side stalls (in_ready = 0) while the new wr_bank is still full. It resumes the cycle after that bank is released.
- Read is accepted when rd_req && full[rd_bank] && rd_col < COLS.
  - Next cycle: rd_valid = 1 and rd_data holds the column.
  - Otherwise: rd_valid = 0 next cycle and rd_data holds its last value.
- rd_release:
  - If full[rd_bank] = 1: clear full[rd_bank] and toggle rd_bank.
  - If full[rd_bank] = 0: ignored.
- Simultaneous events:
  - rd_req and rd_release in the same cycle: the read is served from the pre-release bank. rd_valid and rd_data follow the normal 1-cycle rule. The release takes effect in the same edge.
  - Final write into bank A and release of bank B in the same cycle: both take effect. full becomes {A set, B clear}, so in_ready is 1 next cycle.
  - The writer never targets a full bank, so a fill and a release of the same bank cannot coincide.
- Partial banks are never readable. A bank is visible to the reader only when full.

## Timing
- Reset values:
  - in_ready = 1.
  - rd_valid = 0, rd_data = 0.
  - bank_full = 2'b00, rd_bank = 0, wr_bank = 0.
  - Counters = 0.
- Reset mid-fill discards the partial bank and any full banks.
- Write-to-full latency: bank_full updates the cycle after the last accepted write.
- Read latency: 1 cycle from rd_req to rd_valid/rd_data, registered.
- Release: bank_full and rd_bank update 1 cycle after rd_release. in_ready follows combinationally.
- Throughput: one pixel per cycle on the write side and one column per cycle on the read side, concurrently.

## Configuration
- CAM_BUF_MEM_CLR_EN defined:
  - Reset zeroes the entire storage array.
  - Storage is a register array.
- CAM_BUF_MEM_CLR_EN undefined:
  - Storage has no reset, so it is SRAM/LUT-RAM inferable. Contents are undefined after reset.
  - Control, flags and outputs still reset as in Timing.
  - Observable behaviour is identical, because only full banks are readable and every location of a full bank has been written.

## Structure
- Package cam_buf_pkg holds:
  - The default DATA_W, ROWS and COLS constants.
  - A localparam helper for the counter widths ($clog2).
- Sub-module cam_buf_bank:
  - One ROWS×COLS storage with a single write port (row, col, data, we) and a registered whole-column read port.
  - Instantiated twice.
  - Holds the CAM_BUF_MEM_CLR_EN ifdef.
- The top holds the counters, flags, bank select and rd_data output mux/register.

## Test plan
- Fill bank 0 with pixel k = k mod 256, k = 0..883:
  - Expect bank_full = 01 one cycle after the 884th write, and in_ready stays 1.
  - rd_req with rd_col = 0 gives rd_valid next cycle and rd_data bytes MSB→LSB = 0,1,…,25.
  - rd_col = 33 gives bytes 858..883 mod 256.
- Write 1768 pixels with no release:
  - Expect bank_full = 11 and in_ready = 0.
  - A 1769th pixel is held, not stored.
  - Pulse rd_release: rd_bank = 1 and in_ready = 1 on the next cycle, and the held pixel lands at bank 0 row 0 col 0.
- rd_req while bank_full = 00, and rd_req with rd_col = 34 while the bank is full: both give rd_valid = 0 and rd_data unchanged.
- rd_req (col 5) and rd_release in the same cycle: rd_data carries bank 0 column 5, and rd_bank = 1 the same cycle rd_valid rises.
- Assert rst after 300 writes:
  - Outputs take their reset values.
  - The next 884 writes fill bank 0 cleanly, with column 0 starting at the first post-reset pixel.
- Run with and without CAM_BUF_MEM_CLR_EN: identical rd_data traces for the scenarios above.
